// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - EX/MEM stage bus: EX-side inputs, MEM-side outputs, handshakes
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int CNT_W  = 16
);
    logic              inValid;
    logic              inReady;
    logic              flush;
    logic [WB_W-1:0]   WB2;
    logic [2:0]        M2;
    logic [DATA_W-1:0] fAddR;
    logic              ZF;
    logic [DATA_W-1:0] fALU;
    logic [DATA_W-1:0] fIDEXrd;
    logic [REG_W-1:0]  fMux5;
    logic              outValid;
    logic              outReady;
    logic [WB_W-1:0]   Wb2;
    logic              Branch;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] tMux32;
    logic              ZFtAND;
    logic [DATA_W-1:0] AluRes;
    logic [DATA_W-1:0] tWriteData;
    logic [REG_W-1:0]  toMEMWB;
    logic              PCSrc;
    logic [CNT_W-1:0]  stallCnt;

    modport master (
        output inValid, flush, WB2, M2, fAddR, ZF, fALU, fIDEXrd, fMux5, outReady,
        input  inReady, outValid, Wb2, Branch, MemRead, MemWrite, tMux32, ZFtAND,
               AluRes, tWriteData, toMEMWB, PCSrc, stallCnt
    );

    modport slave (
        input  inValid, flush, WB2, M2, fAddR, ZF, fALU, fIDEXrd, fMux5, outReady,
        output inReady, outValid, Wb2, Branch, MemRead, MemWrite, tMux32, ZFtAND,
               AluRes, tWriteData, toMEMWB, PCSrc, stallCnt
    );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - elastic EX/MEM pipeline register; EXMEM_SKID_EN adds a skid entry
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int CNT_W  = 16
) (
    input logic           clkEXMEM,
    input logic           rstEXMEM_n,
    ex_mem_stage_if.slave bus
);
    localparam int ENT_W = WB_W + 3 + 3 * DATA_W + 1 + REG_W;

    logic [ENT_W-1:0] inEntry;
    logic [ENT_W-1:0] mainEntry;
    logic             mainValid;
    logic [WB_W-1:0]  wbHeld;
    logic [2:0]       mHeld;
    logic [CNT_W-1:0] stallReg;
    logic             accept;
    logic             consume;
    logic             mainFree;

    assign inEntry = {bus.WB2, bus.M2, bus.fAddR, bus.ZF, bus.fALU, bus.fIDEXrd, bus.fMux5};
    assign {wbHeld, mHeld, bus.tMux32, bus.ZFtAND, bus.AluRes, bus.tWriteData, bus.toMEMWB} = mainEntry;

    // an input offered during a flush is dropped even though upstream sees it as taken
    assign accept   = bus.inValid & bus.inReady & ~bus.flush;
    assign consume  = mainValid & bus.outReady;
    assign mainFree = consume | ~mainValid;

`ifdef EXMEM_SKID_EN
    logic [ENT_W-1:0] skidEntry;
    logic             skidValid;

    // main/skid pair: skid only fills while main is stalled, and drains into main first
    always_ff @(posedge clkEXMEM or negedge rstEXMEM_n) begin
        if (!rstEXMEM_n) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            mainEntry <= '0;
            skidEntry <= '0;
        end else if (bus.flush) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
        end else if (mainFree) begin
            if (skidValid) begin
                mainEntry <= skidEntry;
                mainValid <= 1'b1;
                skidValid <= 1'b0;
            end else begin
                mainValid <= accept;
                if (accept) mainEntry <= inEntry;
            end
        end else if (accept) begin
            skidEntry <= inEntry;
            skidValid <= 1'b1;
        end
    end

    // registered ready: no combinational path from outReady back to EX
    assign bus.inReady = ~skidValid;
`else
    // single entry: reload whenever the held entry leaves or the slot is empty
    always_ff @(posedge clkEXMEM or negedge rstEXMEM_n) begin
        if (!rstEXMEM_n) begin
            mainValid <= 1'b0;
            mainEntry <= '0;
        end else if (bus.flush) begin
            mainValid <= 1'b0;
        end else if (mainFree) begin
            mainValid <= accept;
            if (accept) mainEntry <= inEntry;
        end
    end

    assign bus.inReady = bus.outReady | ~mainValid;
`endif

    // count edges where MEM back-pressures a valid entry; sticks at all-ones
    always_ff @(posedge clkEXMEM or negedge rstEXMEM_n) begin
        if (!rstEXMEM_n) begin
            stallReg <= '0;
        end else if (mainValid & ~bus.outReady & ~bus.flush & (stallReg != '1)) begin
            stallReg <= stallReg + 1'b1;
        end
    end

    // control fields are forced low on bubbles so MEM/WB never act on stale data
    assign bus.outValid = mainValid;
    assign bus.Wb2      = mainValid ? wbHeld : '0;
    assign bus.Branch   = mainValid & mHeld[0];
    assign bus.MemRead  = mainValid & mHeld[1];
    assign bus.MemWrite = mainValid & mHeld[2];
    assign bus.PCSrc    = mainValid & mHeld[0] & bus.ZFtAND;
    assign bus.stallCnt = stallReg;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage (both EXMEM_SKID_EN modes)
module tb_ex_mem_stage;
`ifdef EXMEM_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        logic [31:0] alu;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic        zf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nFail;
    exp_t sb[$];
    exp_t front;

    ex_mem_stage_if #(.DATA_W(32), .REG_W(5), .WB_W(2), .CNT_W(4)) bus();

    ex_mem_stage #(.DATA_W(32), .REG_W(5), .WB_W(2), .CNT_W(4)) dut (
        .clkEXMEM  (clk),
        .rstEXMEM_n(rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // one clock of stimulus; entered and left at posedge+1
    task automatic cycle(input logic v, input logic rdy, input logic fl, input logic [31:0] alu,
                         input logic [1:0] wb, input logic [2:0] m, input logic zf, input logic expReady);
        exp_t e;
        bus.inValid  = v;
        bus.outReady = rdy;
        bus.flush    = fl;
        bus.fALU     = alu;
        bus.WB2      = wb;
        bus.M2       = m;
        bus.ZF       = zf;
        bus.fAddR    = alu + 32'd100;
        bus.fIDEXrd  = ~alu;
        bus.fMux5    = alu[4:0];
        #2;
        check("inReady", {31'b0, bus.inReady}, {31'b0, expReady});
        if (v && expReady && !fl) begin
            e.alu = alu; e.wb = wb; e.m = m; e.zf = zf;
            sb.push_back(e);
        end
        @(posedge clk);
        if (fl) sb.delete();
        #1;
    endtask

    // monitor: compare held entry against scoreboard front, pop on consume
    always @(negedge clk) begin
        if (rst_n && bus.outValid) begin
            if (sb.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected_out: got AluRes 0x%0h, expected no entry at %0t", bus.AluRes, $time);
            end else begin
                front = sb[0];
                check("AluRes", bus.AluRes, front.alu);
                check("tMux32", bus.tMux32, front.alu + 32'd100);
                check("tWriteData", bus.tWriteData, ~front.alu);
                check("toMEMWB", {27'b0, bus.toMEMWB}, {27'b0, front.alu[4:0]});
                check("ctrl", {26'b0, bus.Wb2, bus.MemWrite, bus.MemRead, bus.Branch, bus.ZFtAND},
                      {26'b0, front.wb, front.m, front.zf});
                check("PCSrc", {31'b0, bus.PCSrc}, {31'b0, front.m[0] & front.zf});
                if (bus.outReady) void'(sb.pop_front());
            end
        end else begin
            check("bubble_ctrl", {27'b0, bus.Wb2, bus.MemWrite, bus.MemRead, bus.Branch, bus.PCSrc}, 32'd0);
        end
    end

    initial begin
        nChecks = 0;
        nFail   = 0;
        rst_n   = 1'b0;
        bus.inValid = 1'b0; bus.outReady = 1'b0; bus.flush = 1'b0;
        bus.WB2 = '0; bus.M2 = '0; bus.ZF = 1'b0;
        bus.fALU = '0; bus.fAddR = '0; bus.fIDEXrd = '0; bus.fMux5 = '0;

        #3;
        check("rst_outValid", {31'b0, bus.outValid}, 32'd0);
        check("rst_inReady", {31'b0, bus.inReady}, 32'd1);
        check("rst_PCSrc", {31'b0, bus.PCSrc}, 32'd0);
        check("rst_stallCnt", {28'b0, bus.stallCnt}, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // stream at full throughput
        cycle(1, 1, 0, 32'd1, 2'b01, 3'b000, 0, 1);
        cycle(1, 1, 0, 32'd2, 2'b10, 3'b100, 1, 1);
        cycle(1, 1, 0, 32'd3, 2'b11, 3'b010, 0, 1);
        check("stream_outValid", {31'b0, bus.outValid}, 32'd1);
        cycle(0, 1, 0, 32'd0, 2'b00, 3'b000, 0, 1);
        cycle(0, 1, 0, 32'd0, 2'b00, 3'b000, 0, 1);
        check("stream_stallCnt", {28'b0, bus.stallCnt}, 32'd0);

        // stall with 0xA5 held; 0x5A offered throughout
        cycle(1, 1, 0, 32'hA5, 2'b01, 3'b010, 0, 1);
        cycle(1, 0, 0, 32'h5A, 2'b10, 3'b100, 1, SKID);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 32'h5A, 2'b10, 3'b100, 1, 1'b0);
        check("stall_stallCnt", {28'b0, bus.stallCnt}, 32'd4);
        check("stall_AluRes", bus.AluRes, 32'hA5);
        cycle(!SKID, 1, 0, 32'h5A, 2'b10, 3'b100, 1, !SKID);
        cycle(0, 1, 0, 32'd0, 2'b00, 3'b000, 0, 1);
        check("post_stall_stallCnt", {28'b0, bus.stallCnt}, 32'd4);

        // flush while an entry is held; flush-cycle input must vanish
        cycle(1, 1, 0, 32'h11, 2'b11, 3'b010, 0, 1);
        cycle(0, 0, 0, 32'd0, 2'b00, 3'b000, 0, SKID);
        cycle(1, 0, 1, 32'h33, 2'b11, 3'b010, 0, SKID);
        check("flush_outValid", {31'b0, bus.outValid}, 32'd0);
        check("flush_MemRead", {31'b0, bus.MemRead}, 32'd0);
        check("flush_Wb2", {30'b0, bus.Wb2}, 32'd0);
        check("flush_stallCnt", {28'b0, bus.stallCnt}, 32'd5);
        cycle(0, 1, 0, 32'd0, 2'b00, 3'b000, 0, 1);

        // branch decision
        cycle(1, 1, 0, 32'h44, 2'b01, 3'b001, 1, 1);
        check("branch_taken", {31'b0, bus.PCSrc}, 32'd1);
        cycle(0, 1, 0, 32'd0, 2'b00, 3'b000, 0, 1);
        check("branch_bubble", {31'b0, bus.PCSrc}, 32'd0);
        cycle(1, 1, 0, 32'h55, 2'b01, 3'b001, 0, 1);
        check("branch_not_taken", {31'b0, bus.PCSrc}, 32'd0);
        cycle(0, 1, 0, 32'd0, 2'b00, 3'b000, 0, 1);

        // saturation of the 4-bit stall counter
        cycle(1, 1, 0, 32'h66, 2'b10, 3'b100, 0, 1);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 32'd0, 2'b00, 3'b000, 0, SKID);
        check("sat_stallCnt", {28'b0, bus.stallCnt}, 32'd15);

        // asynchronous reset between edges while stalled
        #3 rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_outValid", {31'b0, bus.outValid}, 32'd0);
        check("arst_stallCnt", {28'b0, bus.stallCnt}, 32'd0);
        check("arst_Wb2", {30'b0, bus.Wb2}, 32'd0);
        check("arst_inReady", {31'b0, bus.inReady}, 32'd1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(0, 1, 0, 32'd0, 2'b00, 3'b000, 0, 1);
        cycle(0, 1, 0, 32'd0, 2'b00, 3'b000, 0, 1);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised, elastic EX/MEM pipeline register and the successor to the fixed 32-bit free-running stage.
- Adds valid/ready flow control, synchronous flush (bubble insertion), control-field gating on bubbles, a registered branch-decision output and a saturating stall counter.
- Sits between the EX stage (ALU, branch adder, dest-reg mux) and the MEM stage / data memory.

Parameters:
DATA_W, 32, width of branch target, ALU result and store data
REG_W, 5, width of destination register index
WB_W, 2, width of write-back control bundle
CNT_W, 16, width of stall counter

Ports:
clkEXMEM  in  1  stage clock, rising edge
rstEXMEM_n  in  1  asynchronous active-low reset
inValid  in  1  EX presents a valid instruction
inReady  out  1  stage can accept this cycle
flush  in  1  synchronous kill of all held and incoming entries
WB2  in  WB_W  write-back control
M2  in  3  mem control; [0] Branch, [1] MemRead, [2] MemWrite
fAddR  in  DATA_W  branch target
ZF  in  1  ALU zero flag
fALU  in  DATA_W  ALU result
fIDEXrd  in  DATA_W  store data
fMux5  in  REG_W  destination register
outValid  out  1  MEM-side entry valid
outReady  in  1  MEM stage consumes this cycle
Wb2  out  WB_W  registered write-back control
Branch, MemRead, MemWrite  out  1 each  decoded from M2
tMux32  out  DATA_W  registered fAddR
ZFtAND  out  1  registered ZF
AluRes  out  DATA_W  registered fALU
tWriteData  out  DATA_W  registered fIDEXrd
toMEMWB  out  REG_W  registered fMux5
PCSrc  out  1  Branch & ZFtAND & outValid (combinational from regs)
stallCnt  out  CNT_W  cycles with outValid & ~outReady

Behaviour:
- Reset (async, rstEXMEM_n=0): all registers 0; outValid=0, inReady=1, PCSrc=0, stallCnt=0. Takes effect immediately, including mid-transfer; any held entry is lost.
- Handshakes:
  - Accept on rising edge when inValid & inReady & ~flush.
  - Consume when outValid & outReady.
  - Latency: 1 cycle input to output. Full throughput: 1 per clock.
- Main register load: a new entry loads when the held entry is consumed or absent.
  - Simultaneous accept and consume: new entry loads, outValid stays 1.
  - Consume without accept: outValid goes 0.
- Held entry: while outValid & ~outReady, all outputs hold stable.
- Bubble gating: while outValid=0, Wb2, Branch, MemRead, MemWrite and PCSrc are 0. Data fields (tMux32, AluRes, tWriteData, toMEMWB, ZFtAND) hold last value and are don't-care.
- Flush: synchronous, highest priority.
  - Next edge: outValid=0 and skid entry (if present) discarded.
  - Input presented in the flush cycle is dropped; upstream treats it as taken.
  - inReady=1 in the cycle after a flush.
- stallCnt:
  - +1 each edge with outValid & ~outReady & ~flush.
  - Saturates at 2^CNT_W-1, with no wrap.
  - Cleared only by reset.

Optional Feature:
EXMEM_SKID_EN
- Defined: 2-entry elastic stage (main + skid). inReady is a registered value, =~skidValid, with no combinational path from outReady.
  - If main is stalled and an input is accepted, the input goes to skid.
  - On consume with skid valid, skid moves to main the same edge and skidValid clears.
  - Entry order is preserved.
- Undefined: single entry; inReady = outReady | ~outValid (combinational).
- Both modes: identical latency, reset and flush behaviour.

Test Plan:
- Reset then stream: inValid=1, outReady=1, fALU=1,2,3 on consecutive edges -> AluRes=1,2,3 one cycle later each; outValid=1 from first+1; stallCnt=0.
- Stall: hold outReady=0 for 4 cycles with entry fALU=0xA5 -> AluRes stays 0xA5, stallCnt=4. Undefined macro: inReady=0. Defined macro: one more entry (0x5A) accepted into skid, then inReady=0. On release, order is 0xA5 then 0x5A.
- Flush during stall: entry M2=3'b010 held, flush=1 one cycle -> outValid=0, MemRead=0, Wb2=0 next edge; input offered that cycle never appears.
- Branch: M2=3'b001, ZF=1 accepted -> PCSrc=1 one cycle later. Then a bubble -> PCSrc=0. M2=3'b001, ZF=0 -> PCSrc=0.
- Saturation: CNT_W=4, outReady=0 for 20 cycles -> stallCnt holds 15.
- Async reset mid-stall: rstEXMEM_n low between edges -> outValid, stallCnt, Wb2 = 0 immediately; inReady=1.
